data_mem_port: RTL and testbench

- Data-memory port downstream of the MEM stage.
- Consumes MEM's word-aligned read address and byte-sized write requests (size codes 0=word, 1=byte, 2=half, 3=three bytes, as used for SB/SH/SW/SWL/SWR).
- Services each request from an internal big-endian RAM with configurable multi-cycle latency.
- Returns the read word and a stall to freeze the pipeline while an access is in flight.

---
 rtl/data_mem_port.sv | 186 ++++++++++++++++++
 tb/tb_data_mem_port.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_port.sv
// Data-memory port behind the MEM stage: big-endian word RAM with byte-granular
// writes, fixed multi-cycle latency, and a combinational pipeline stall.
module data_mem_port #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BAD_READ    = 32'hDEADBEEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] data_address_fMEM,
    input  logic [31:0] data_write_fMEM,
    input  logic [1:0]  data_write_size_fMEM,
    input  logic        MemRead_fMEM,
    input  logic        MemWrite_fMEM,
    output logic [31:0] data_read_2MEM,
    output logic        data_stall_2PIPE,
    output logic        data_err_2PIPE
);

    localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        write_q, write_d;
    logic        both_q, both_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req;
    logic        commit;
    logic        mem_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [1:0]  acc_size;
    logic        acc_write;
    logic        acc_both;
    logic        in_range;
    logic [AW-1:0] ram_idx;
    logic [31:0] ram_word;
    logic [31:0] merged;

    logic [31:0] mem [DEPTH_WORDS];

    assign req = MemRead_fMEM | MemWrite_fMEM;

    // With LATENCY==1 the commit happens on the accepting edge, so the live
    // inputs must be used there instead of the not-yet-captured registers.
    always_comb begin
        if (state_q == IDLE) begin
            acc_addr  = data_address_fMEM;
            acc_wdata = data_write_fMEM;
            acc_size  = data_write_size_fMEM;
            acc_write = MemWrite_fMEM;
            acc_both  = MemRead_fMEM & MemWrite_fMEM;
        end else begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_size  = size_q;
            acc_write = write_q;
            acc_both  = both_q;
        end
    end

    assign in_range = {2'b00, acc_addr[31:2]} < 32'(DEPTH_WORDS);
    assign ram_idx  = acc_addr[AW+1:2];
    assign ram_word = mem[ram_idx];

    always_comb begin : merge_c
        int off;
        int num;
        int src;
        merged = ram_word;
        off    = int'(acc_addr[1:0]);
        num    = (acc_size == 2'd0) ? 4 : int'(acc_size);
        src    = 0;
        for (int b = 0; b < 4; b++) begin
            if (b >= off && b < off + num) begin
                src = num - 1 - (b - off);
                merged[(3 - b) * 8 +: 8] = acc_wdata[src * 8 +: 8];
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        size_d           = size_q;
        write_d          = write_q;
        both_d           = both_q;
        rdata_d          = rdata_q;
        err_d            = 1'b0;
        commit           = 1'b0;
        data_stall_2PIPE = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    data_stall_2PIPE = 1'b1;
                    addr_d           = data_address_fMEM;
                    wdata_d          = data_write_fMEM;
                    size_d           = data_write_size_fMEM;
                    write_d          = MemWrite_fMEM;
                    both_d           = MemRead_fMEM & MemWrite_fMEM;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                data_stall_2PIPE = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (commit) begin
            err_d = acc_both | ~in_range;
            if (!acc_write) begin
                rdata_d = in_range ? ram_word : BAD_READ;
            end
        end
    end

    assign mem_we = commit & acc_write & in_range;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'd0;
            write_q <= 1'b0;
            both_q  <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            write_q <= write_d;
            both_q  <= both_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM keeps its contents across reset; a reset on the commit edge drops the write.
    always_ff @(posedge CLK) begin
        if (!RESET && mem_we) begin
            mem[ram_idx] <= merged;
        end
    end

    assign data_read_2MEM = rdata_q;
    assign data_err_2PIPE = err_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Self-checking bench for data_mem_port: two instances (LATENCY 2 and 4) driven
// by directed and random accesses, checked against a byte-level reference model.
module tb_data_mem_port;

    localparam logic [31:0] BAD = 32'hDEADBEEF;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] addr_in   [2];
    logic [31:0] wdata_in  [2];
    logic [1:0]  size_in   [2];
    logic        rd_in     [2];
    logic        wr_in     [2];
    logic [31:0] rdata_out [2];
    logic        stall_out [2];
    logic        err_out   [2];

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    bit [31:0]   model_mem [longint];
    logic [31:0] last_read [2];
    bit          in_done   [2];

    always #5 CLK = ~CLK;

    data_mem_port #(.DEPTH_WORDS(1024), .LATENCY(2), .BAD_READ(BAD)) u_dut_l2 (
        .CLK                  (CLK),
        .RESET                (RESET),
        .data_address_fMEM    (addr_in[0]),
        .data_write_fMEM      (wdata_in[0]),
        .data_write_size_fMEM (size_in[0]),
        .MemRead_fMEM         (rd_in[0]),
        .MemWrite_fMEM        (wr_in[0]),
        .data_read_2MEM       (rdata_out[0]),
        .data_stall_2PIPE     (stall_out[0]),
        .data_err_2PIPE       (err_out[0])
    );

    data_mem_port #(.DEPTH_WORDS(64), .LATENCY(4), .BAD_READ(BAD)) u_dut_l4 (
        .CLK                  (CLK),
        .RESET                (RESET),
        .data_address_fMEM    (addr_in[1]),
        .data_write_fMEM      (wdata_in[1]),
        .data_write_size_fMEM (size_in[1]),
        .MemRead_fMEM         (rd_in[1]),
        .MemWrite_fMEM        (wr_in[1]),
        .data_read_2MEM       (rdata_out[1]),
        .data_stall_2PIPE     (stall_out[1]),
        .data_err_2PIPE       (err_out[1])
    );

    function automatic int latOf(input int w);
        return (w == 0) ? 2 : 4;
    endfunction

    function automatic int depthOf(input int w);
        return (w == 0) ? 1024 : 64;
    endfunction

    function automatic longint keyOf(input int w, input logic [31:0] addr);
        return longint'(w) * 64'h1_0000_0000 + longint'(addr >> 2);
    endfunction

    function automatic logic [31:0] modelRead(input int w, input logic [31:0] addr);
        longint key;
        if ((addr >> 2) >= 32'(depthOf(w))) return BAD;
        key = keyOf(w, addr);
        if (model_mem.exists(key)) return model_mem[key];
        return 32'd0;
    endfunction

    // The word is viewed as four bytes, byte 0 being the most significant;
    // the N data bytes land at offsets o, o+1, ... and anything past byte 3 is lost.
    function automatic void modelWrite(input int w, input logic [31:0] addr,
                                       input logic [31:0] data, input logic [1:0] size);
        longint     key;
        logic [7:0] b [4];
        logic [31:0] word;
        int n;
        int o;
        if ((addr >> 2) >= 32'(depthOf(w))) return;
        key  = keyOf(w, addr);
        word = model_mem.exists(key) ? model_mem[key] : 32'd0;
        n    = (size == 2'd0) ? 4 : int'(size);
        o    = int'(addr[1:0]);
        for (int p = 0; p < 4; p++) b[p] = word[31 - 8 * p -: 8];
        for (int j = 0; j < n; j++) begin
            if (o + j <= 3) b[o + j] = data[8 * (n - 1 - j) +: 8];
        end
        model_mem[key] = {b[0], b[1], b[2], b[3]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int w, input bit rd, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [1:0] size);
        rd_in[w]    = rd;
        wr_in[w]    = wr;
        addr_in[w]  = addr;
        wdata_in[w] = data;
        size_in[w]  = size;
        #1;
    endtask

    // One complete access, entered at a falling edge; leaves the DUT in DONE
    // with the request still asserted so a following call runs back-to-back.
    task automatic doAccess(input int w, input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [1:0] size);
        int    gap;
        int    n;
        bit    exp_err;
        string t;
        t       = $sformatf("L%0d %s@%08h", latOf(w), wr ? "wr" : "rd", addr);
        exp_err = (rd && wr) || ((addr >> 2) >= 32'(depthOf(w)));
        if (wr) modelWrite(w, addr, data, size);
        else    last_read[w] = modelRead(w, addr);
        applyStimulus(w, rd, wr, addr, data, size);
        gap = 0;
        while (!stall_out[w] && gap < 4) begin
            gap++;
            @(negedge CLK);
        end
        checkOutput({t, " gap"}, 32'(gap), in_done[w] ? 32'd1 : 32'd0);
        checkOutput({t, " err_before"}, {31'd0, err_out[w]}, 32'd0);
        n = 0;
        while (stall_out[w] && n < 40) begin
            n++;
            @(negedge CLK);
        end
        checkOutput({t, " stall_cycles"}, 32'(n), 32'(latOf(w)));
        checkOutput({t, " rdata"}, rdata_out[w], last_read[w]);
        checkOutput({t, " err"}, {31'd0, err_out[w]}, {31'd0, exp_err});
        in_done[w] = 1'b1;
    endtask

    task automatic idleCycle(input int w);
        applyStimulus(w, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
        @(negedge CLK);
        in_done[w] = 1'b0;
        checkOutput($sformatf("L%0d idle stall", latOf(w)), {31'd0, stall_out[w]}, 32'd0);
        checkOutput($sformatf("L%0d idle err", latOf(w)), {31'd0, err_out[w]}, 32'd0);
        checkOutput($sformatf("L%0d idle rdata", latOf(w)), rdata_out[w], last_read[w]);
    endtask

    task automatic randomPhase(input int w);
        logic [31:0] a;
        int          r;
        for (int i = 0; i < 8; i++) doAccess(w, 1'b0, 1'b1, 32'h80 + 32'(4 * i), $urandom, 2'd0);
        for (int k = 0; k < 25; k++) begin
            r = $urandom_range(0, 9);
            a = 32'h80 + 32'(4 * $urandom_range(0, 7));
            if (r <= 3) begin
                doAccess(w, 1'b1, 1'b0, a, $urandom, 2'($urandom));
            end else if (r <= 7) begin
                doAccess(w, 1'b0, 1'b1, a + 32'($urandom_range(0, 3)), $urandom, 2'($urandom));
            end else if (r == 8) begin
                doAccess(w, 1'b1, 1'b1, a + 32'($urandom_range(0, 3)), $urandom, 2'($urandom));
            end else begin
                a = 32'(depthOf(w) * 4) + 32'(4 * $urandom_range(0, 15));
                doAccess(w, 1'b0, 1'b1, a, $urandom, 2'd0);
                doAccess(w, 1'b1, 1'b0, a, 32'd0, 2'd0);
            end
            if ($urandom_range(0, 1) == 1) idleCycle(w);
        end
        idleCycle(w);
    endtask

    initial begin
        for (int w = 0; w < 2; w++) begin
            rd_in[w] = 1'b0; wr_in[w] = 1'b0; addr_in[w] = 32'd0;
            wdata_in[w] = 32'd0; size_in[w] = 2'd0;
            last_read[w] = 32'd0; in_done[w] = 1'b0;
        end
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        for (int w = 0; w < 2; w++) begin
            checkOutput($sformatf("L%0d reset stall", latOf(w)), {31'd0, stall_out[w]}, 32'd0);
            checkOutput($sformatf("L%0d reset rdata", latOf(w)), rdata_out[w], 32'd0);
            checkOutput($sformatf("L%0d reset err", latOf(w)), {31'd0, err_out[w]}, 32'd0);
        end

        $display("[TB] directed accesses, LATENCY=2");
        doAccess(0, 1'b0, 1'b1, 32'h10, 32'h11223344, 2'd0);
        doAccess(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'd0);
        doAccess(0, 1'b0, 1'b1, 32'h12, 32'h000000AB, 2'd1);
        doAccess(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'd0);
        idleCycle(0);
        doAccess(0, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 2'd0);
        doAccess(0, 1'b0, 1'b1, 32'h21, 32'h00123456, 2'd3);
        doAccess(0, 1'b1, 1'b0, 32'h20, 32'd0, 2'd0);
        doAccess(0, 1'b0, 1'b1, 32'h20, 32'h00778899, 2'd3);
        doAccess(0, 1'b1, 1'b0, 32'h20, 32'd0, 2'd0);
        idleCycle(0);
        doAccess(0, 1'b0, 1'b1, 32'h30, 32'h00000000, 2'd0);
        doAccess(0, 1'b0, 1'b1, 32'h34, 32'h55555555, 2'd0);
        doAccess(0, 1'b0, 1'b1, 32'h33, 32'h0000BEEF, 2'd2);
        doAccess(0, 1'b1, 1'b0, 32'h30, 32'd0, 2'd0);
        doAccess(0, 1'b1, 1'b0, 32'h34, 32'd0, 2'd0);
        idleCycle(0);
        doAccess(0, 1'b1, 1'b0, 32'h1000, 32'd0, 2'd0);
        idleCycle(0);
        doAccess(0, 1'b1, 1'b1, 32'h50, 32'h0BADF00D, 2'd0);
        idleCycle(0);
        doAccess(0, 1'b1, 1'b0, 32'h50, 32'd0, 2'd0);
        idleCycle(0);

        $display("[TB] random accesses, LATENCY=2");
        randomPhase(0);

        $display("[TB] reset during a LATENCY=4 write");
        doAccess(1, 1'b0, 1'b1, 32'h40, 32'h00000000, 2'd0);
        doAccess(1, 1'b0, 1'b1, 32'h10, 32'h11223344, 2'd0);
        doAccess(1, 1'b1, 1'b0, 32'h10, 32'd0, 2'd0);
        idleCycle(1);
        applyStimulus(1, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 2'd0);
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("L4 busy2 stall", {31'd0, stall_out[1]}, 32'd1);
        RESET = 1'b1;
        applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
        @(negedge CLK);
        RESET = 1'b0;
        last_read[0] = 32'd0;
        last_read[1] = 32'd0;
        in_done[0]   = 1'b0;
        in_done[1]   = 1'b0;
        checkOutput("L4 post-reset stall", {31'd0, stall_out[1]}, 32'd0);
        checkOutput("L4 post-reset rdata", rdata_out[1], 32'd0);
        checkOutput("L4 post-reset err", {31'd0, err_out[1]}, 32'd0);
        checkOutput("L2 post-reset rdata", rdata_out[0], 32'd0);
        doAccess(1, 1'b1, 1'b0, 32'h40, 32'd0, 2'd0);
        idleCycle(1);
        doAccess(1, 1'b1, 1'b0, 32'h100, 32'd0, 2'd0);
        idleCycle(1);

        $display("[TB] random accesses, LATENCY=4");
        randomPhase(1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
